// File: rtl/ex_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : ex_mem
// Purpose  : EX->MEM pipeline register with stall/flush handling and HI/LO
//            multiply-accumulate progress loop-back to execute.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        mem_valid,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  localparam int c_ex_stall  = 3;
  localparam int c_mem_stall = 4;

  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_wdata;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_whilo;
  logic        r_valid;
  logic [63:0] r_hilo;
  logic [1:0]  r_cnt;

  // Priority: reset/flush, load (EX running), bubble (EX stalled, MEM free), hold.
  // The illegal EX-running/MEM-stalled pattern falls into the load branch.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_whilo <= 1'b0;
      r_valid <= 1'b0;
      r_hilo  <= '0;
      r_cnt   <= '0;
    end else if (!stall[c_ex_stall]) begin
      r_wd    <= ex_wd;
      r_wreg  <= ex_wreg;
      r_wdata <= ex_wdata;
      r_hi    <= ex_hi;
      r_lo    <= ex_lo;
      r_whilo <= ex_whilo;
      r_valid <= 1'b1;
      r_hilo  <= '0;
      r_cnt   <= '0;
    end else if (!stall[c_mem_stall]) begin
      // Bubble must never commit; the accumulator survives the EX stall.
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_whilo <= 1'b0;
      r_valid <= 1'b0;
      r_hilo  <= hilo_i;
      r_cnt   <= cnt_i;
    end
  end

  assign mem_wd    = r_wd;
  assign mem_wreg  = r_wreg;
  assign mem_wdata = r_wdata;
  assign mem_hi    = r_hi;
  assign mem_lo    = r_lo;
  assign mem_whilo = r_whilo;
  assign mem_valid = r_valid;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

endmodule
`default_nettype wire

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory-access stage of the five-stage MIPS core. It captures the execute result each cycle: destination register, write enable, write data and the HI/LO write request. It obeys the global stall vector and flush. It also loops the partial 64-bit HI/LO accumulation and its cycle counter back to execute, so multi-cycle multiply-accumulate operations keep their progress while execute is stalled.

## Interface
Parameters: none. Widths come from the global defines (`RegBus` 32, `RegAddrBus` 5, `DoubleRegBus` 64).

- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the next rising clk edge)
- stall  in  6  global stall vector; bit 3 = execute stalled, bit 4 = memory stage stalled
- flush  in  1  pipeline flush (exception/redirect); one-cycle pulse
- ex_wd  in  5  destination register address from execute
- ex_wreg  in  1  GPR write enable from execute
- ex_wdata  in  32  GPR write data from execute
- ex_hi  in  32  value for HI
- ex_lo  in  32  value for LO
- ex_whilo  in  1  HI/LO write enable
- hilo_i  in  64  partial accumulation result from execute
- cnt_i  in  2  accumulation cycle count from execute
- mem_wd  out  5  registered destination address
- mem_wreg  out  1  registered GPR write enable
- mem_wdata  out  32  registered GPR write data
- mem_hi  out  32  registered HI value
- mem_lo  out  32  registered LO value
- mem_whilo  out  1  registered HI/LO write enable
- mem_valid  out  1  1 = slot holds a real instruction; 0 = bubble
- hilo_o  out  64  accumulation value returned to execute
- cnt_o  out  2  accumulation count returned to execute

## Operation
The block evaluates these actions in priority order, once per rising clk. Exactly one action applies.

1. **Reset.** Applies when rst==0. All outputs go to 0, including mem_valid, hilo_o and cnt_o.
2. **Flush.** Applies when flush==1. All mem_* outputs and mem_valid go to 0. hilo_o and cnt_o go to 0. Flush overrides every stall combination.
3. **Bubble.** Applies when stall[3]==1 and stall[4]==0.
   - mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo and mem_valid go to 0.
   - hilo_o is loaded from hilo_i and cnt_o from cnt_i, which preserves accumulation progress across the stall.
4. **Load.** Applies when stall[3]==0.
   - mem_* are loaded from the matching ex_* inputs, and mem_valid goes to 1.
   - hilo_o and cnt_o go to 0, because the accumulation completed or was never started.
5. **Hold.** Applies when stall[3]==1 and stall[4]==1. Every output keeps its value.

Other rules:
- stall[3]==0 together with stall[4]==1 is illegal from the controller. The block treats it as Load; verification flags it with an assertion.
- No arithmetic is performed. The block passes values through unmodified at full width.
- A bubble must have mem_wreg==0 and mem_whilo==0, so the memory and write-back stages never commit anything for it.
- stall bits 0–2 and 5 are ignored.

## Timing
- Latency: an ex_* value present before rising edge N appears on mem_* immediately after edge N. That is one cycle, with no combinational path from input to output.
- Loop-back: hilo_o and cnt_o are registered. Execute sees the value captured at edge N during cycle N+1.
- Reset: takes effect only on a clock edge. Outputs are undefined-free (0) from the first edge with rst==0 onward.
- rst deasserted mid-stream: the first edge with rst==1 follows the normal priority using the current inputs.
- Flush coinciding with Load: the flush wins and the incoming instruction is discarded (mem_valid=0).
- A long stall (stall[3]=stall[4]=1 for k cycles) holds the slot for k cycles. On release, the slot resumes with the held values intact.

## Test plan
- **Reset and load.**
  - Drive rst=0 for 2 cycles: every output is 0.
  - Then apply rst=1 with ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678: after one edge, mem_wd=3, mem_wdata=32'h1234_5678, mem_valid=1.
- **Bubble.**
  - Set stall=6'b001000 with hilo_i=64'h0000_0001_FFFF_FFFE and cnt_i=2'b01: mem_wreg=0, mem_whilo=0, mem_valid=0, hilo_o=64'h0000_0001_FFFF_FFFE, cnt_o=1.
  - Next cycle with stall=0: hilo_o=0 and cnt_o=0.
- **Hold.**
  - Load ex_wdata=32'hDEAD_BEEF, then apply stall=6'b011000 for 3 cycles while the ex_* inputs change: mem_wdata stays 32'hDEAD_BEEF and mem_valid stays 1.
  - On release, the new ex_* values load.
- **Flush priority.** Apply flush=1 together with stall=6'b011000 and valid ex_* inputs: all mem_* outputs, hilo_o and cnt_o are 0 after the edge.
- **HI/LO pass-through.** Drive ex_whilo=1, ex_hi=32'hAAAA_0000, ex_lo=32'h0000_5555: mem_whilo=1, mem_hi=32'hAAAA_0000, mem_lo=32'h0000_5555. On the next bubble, mem_whilo=0.
- **Synchronous reset mid-stall.** During a hold, pull rst=0 for one cycle: all outputs are 0 at that edge and not before it, which confirms reset is synchronous.
